// File: rtl/mp3_playback_ctrl.sv
// mp3_playback_ctrl: playback sequencer for the keyboard's MP3 mode.
// It owns the song index and the note address into the song ROM, and steps
// through the notes at a beat rate set by each note's length field. It also
// handles the play/pause/stop/prev/next buttons and gates the tone generator.
// Optional feature macro: MP3_AUTO_NEXT_EN. When it is defined, reaching the
// end of a song moves on to the next song. When it is undefined, reaching the
// end of a song stops playback.
module mp3_playback_ctrl #(
  parameter int SONG_NUM        = 4,
  parameter int ADDR_W          = 8,
  parameter int BEAT_CYCLES     = 12500000,
  parameter int BTN_HOLD_CYCLES = 400000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_play,
  input  logic              btn_stop,
  input  logic              btn_prev,
  input  logic              btn_next,
  input  logic [3:0]        note_len,
  input  logic              song_end,
  output logic [1:0]        select,
  output logic [ADDR_W-1:0] note_addr,
  output logic              tone_en,
  output logic [1:0]        state
);

  localparam int BTN_W  = (BTN_HOLD_CYCLES > 1) ? $clog2(BTN_HOLD_CYCLES) : 1;
  localparam int BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [BTN_W-1:0]  BTN_LAST  = BTN_W'(BTN_HOLD_CYCLES - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
  localparam logic [1:0]        SEL_LAST  = 2'(SONG_NUM - 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_PLAY  = 2'b10,
    ST_PAUSE = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          select_q, select_d;
  logic [ADDR_W-1:0]   note_addr_q, note_addr_d;
  logic [BTN_W-1:0]    btn_cnt_q, btn_cnt_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [3:0]          beats_left_q, beats_left_d;
  logic                tone_en_q;

  logic                sample;
  logic                act_stop, act_play, act_prev, act_next;
  logic [1:0]          sel_prev, sel_next;
  logic                end_of_song;

  // One action per sample cycle. A play press while in LOAD is swallowed,
  // so the lower-priority buttons do not get a turn on that sample.
  assign sample      = (btn_cnt_q == BTN_LAST);
  assign act_stop    = sample & btn_stop;
  assign act_play    = sample & ~btn_stop & btn_play & (state_q != ST_LOAD);
  assign act_prev    = sample & ~btn_stop & ~btn_play & btn_prev;
  assign act_next    = sample & ~btn_stop & ~btn_play & ~btn_prev & btn_next;
  assign sel_prev    = (select_q == 2'd0) ? SEL_LAST : select_q - 2'd1;
  assign sel_next    = (select_q == SEL_LAST) ? 2'd0 : select_q + 2'd1;
  assign end_of_song = song_end | (&note_addr_q);

  // Next-state logic: button actions override note sequencing.
  always_comb begin
    state_d      = state_q;
    select_d     = select_q;
    note_addr_d  = note_addr_q;
    beat_cnt_d   = beat_cnt_q;
    beats_left_d = beats_left_q;
    btn_cnt_d    = sample ? '0 : btn_cnt_q + BTN_W'(1);

    if (act_stop) begin
      state_d      = ST_STOP;
      note_addr_d  = '0;
      beat_cnt_d   = '0;
      beats_left_d = '0;
    end else if (act_play) begin
      case (state_q)
        ST_STOP:  state_d = ST_LOAD;
        ST_PLAY:  state_d = ST_PAUSE;
        // A song change made while paused leaves no note loaded, so resume must reload.
        ST_PAUSE: state_d = (beats_left_q == 4'd0) ? ST_LOAD : ST_PLAY;
        default:  state_d = state_q;
      endcase
    end else if (act_prev | act_next) begin
      select_d     = act_prev ? sel_prev : sel_next;
      note_addr_d  = '0;
      beat_cnt_d   = '0;
      beats_left_d = '0;
      if (state_q == ST_PLAY || state_q == ST_LOAD) begin
        state_d = ST_LOAD;
      end
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (end_of_song) begin
`ifdef MP3_AUTO_NEXT_EN
            select_d    = sel_next;
            note_addr_d = '0;
`else
            state_d     = ST_STOP;
            note_addr_d = '0;
`endif
          end else begin
            beats_left_d = (note_len == 4'd0) ? 4'd1 : note_len;
            beat_cnt_d   = '0;
            state_d      = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (beat_cnt_q == BEAT_LAST) begin
            beat_cnt_d   = '0;
            beats_left_d = beats_left_q - 4'd1;
            if (beats_left_q == 4'd1) begin
              note_addr_d = note_addr_q + ADDR_W'(1);
              state_d     = ST_LOAD;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State and counter registers; tone_en tracks the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_STOP;
      select_q     <= 2'd0;
      note_addr_q  <= '0;
      btn_cnt_q    <= '0;
      beat_cnt_q   <= '0;
      beats_left_q <= 4'd0;
      tone_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      select_q     <= select_d;
      note_addr_q  <= note_addr_d;
      btn_cnt_q    <= btn_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      beats_left_q <= beats_left_d;
      tone_en_q    <= (state_d == ST_PLAY);
    end
  end

  assign select    = select_q;
  assign note_addr = note_addr_q;
  assign tone_en   = tone_en_q;
  assign state     = state_q;

endmodule

// File: tb/tb_mp3_playback_ctrl.sv
// Testbench for mp3_playback_ctrl. A reference model that counts the cycles
// remaining per note pushes the expected outputs into a queue on every clock.
// A monitor pops those entries and compares them on the falling edge. Directed
// checks cover the main scenarios, and random button traffic follows them.
module tb_mp3_playback_ctrl;

  localparam int BEAT  = 4;
  localparam int HOLD  = 8;
  localparam int AW    = 8;
  localparam int SONGS = 4;
  localparam logic [1:0] S_STOP = 2'b00, S_LOAD = 2'b01, S_PLAY = 2'b10, S_PAUSE = 2'b11;
  localparam logic [3:0] B_PLAY = 4'b0001, B_STOP = 4'b0010, B_PREV = 4'b0100, B_NEXT = 4'b1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          btn_play = 1'b0, btn_stop = 1'b0, btn_prev = 1'b0, btn_next = 1'b0;
  logic [3:0]    note_len;
  logic          song_end;
  logic [1:0]    select, state;
  logic [AW-1:0] note_addr;
  logic          tone_en;

  always #5 clk = ~clk;

  // Song ROM shared by every song: lengths {2,1,0,3}, end marker from address 4.
  function automatic int rom_len(input int a);
    case (a)
      0: rom_len = 2;
      1: rom_len = 1;
      2: rom_len = 0;
      3: rom_len = 3;
      default: rom_len = 0;
    endcase
  endfunction

  assign note_len = 4'(rom_len(int'(note_addr)));
  assign song_end = (note_addr >= 8'd4);

  mp3_playback_ctrl #(
    .SONG_NUM(SONGS), .ADDR_W(AW), .BEAT_CYCLES(BEAT), .BTN_HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_play(btn_play), .btn_stop(btn_stop), .btn_prev(btn_prev), .btn_next(btn_next),
    .note_len(note_len), .song_end(song_end),
    .select(select), .note_addr(note_addr), .tone_en(tone_en), .state(state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0]    st;
    logic [1:0]    sel;
    logic [AW-1:0] addr;
    logic          tone;
  } exp_t;
  exp_t exp_q[$];

  int         m_tick = 0;   // cycles since reset within the button period
  logic [1:0] m_mode = S_STOP;
  int         m_sel = 0, m_addr = 0;
  int         m_remain = 0; // PLAY cycles left for the current note, 0 = none loaded

  function automatic void model_step();
    bit smp;
    int act;
    int len;
    if (rst) begin
      m_tick = 0; m_mode = S_STOP; m_sel = 0; m_addr = 0; m_remain = 0;
    end else begin
      smp    = (m_tick == HOLD - 1);
      m_tick = smp ? 0 : m_tick + 1;
      act = 0;
      if (smp) begin
        if (btn_stop) act = 1;
        else if (btn_play) act = 2;
        else if (btn_prev) act = 3;
        else if (btn_next) act = 4;
      end
      if (act == 2 && m_mode == S_LOAD) act = 0;
      case (act)
        1: begin m_mode = S_STOP; m_addr = 0; m_remain = 0; end
        2: begin
          if (m_mode == S_STOP) m_mode = S_LOAD;
          else if (m_mode == S_PLAY) m_mode = S_PAUSE;
          else if (m_mode == S_PAUSE) m_mode = (m_remain == 0) ? S_LOAD : S_PLAY;
        end
        3, 4: begin
          m_sel    = (act == 3) ? (m_sel + SONGS - 1) % SONGS : (m_sel + 1) % SONGS;
          m_addr   = 0;
          m_remain = 0;
          if (m_mode == S_PLAY || m_mode == S_LOAD) m_mode = S_LOAD;
        end
        default: begin
          if (m_mode == S_LOAD) begin
            if (m_addr >= 4 || m_addr == 255) begin
`ifdef MP3_AUTO_NEXT_EN
              m_sel  = (m_sel + 1) % SONGS;
              m_addr = 0;
`else
              m_mode = S_STOP;
              m_addr = 0;
`endif
            end else begin
              len      = rom_len(m_addr);
              m_remain = ((len == 0) ? 1 : len) * BEAT;
              m_mode   = S_PLAY;
            end
          end else if (m_mode == S_PLAY) begin
            m_remain = m_remain - 1;
            if (m_remain == 0) begin
              m_addr = m_addr + 1;
              m_mode = S_LOAD;
            end
          end
        end
      endcase
    end
    exp_q.push_back('{st: m_mode, sel: 2'(m_sel), addr: AW'(m_addr), tone: (m_mode == S_PLAY)});
  endfunction

  always @(posedge clk) model_step();

  // ---------------- scoreboard monitor ----------------
  task automatic scoreboard_check();
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("sb_state", 32'(state), 32'(e.st));
      chk("sb_select", 32'(select), 32'(e.sel));
      chk("sb_note_addr", 32'(note_addr), 32'(e.addr));
      chk("sb_tone_en", 32'(tone_en), 32'(e.tone));
    end
  endtask

  always @(negedge clk) scoreboard_check();

  // ---------------- tone run recorder ----------------
  typedef struct {
    int addr;
    int len;
  } run_t;
  run_t run_q[$];
  int   run_addr = 0, run_len = 0;
  logic prev_tone = 1'b0;

  task automatic record_runs();
    if (tone_en === 1'b1 && prev_tone !== 1'b1) begin
      run_addr = int'(note_addr);
      run_len  = 1;
    end else if (tone_en === 1'b1) begin
      run_len++;
    end else if (prev_tone === 1'b1) begin
      run_q.push_back('{addr: run_addr, len: run_len});
    end
    prev_tone = tone_en;
  endtask

  always @(negedge clk) record_runs();

  // ---------------- stimulus helpers ----------------
  // Wait for the falling edge just before a sample cycle, optionally in PLAY at an address.
  task automatic wait_smp(input bit need_play, input int need_addr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_tick == HOLD - 1 &&
          (!need_play || state == S_PLAY) &&
          (need_addr < 0 || int'(note_addr) == need_addr)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic press(input logic [3:0] m, input bit need_play, input int need_addr,
                       output logic [1:0] sel_at);
    bit ok;
    wait_smp(need_play, need_addr, ok);
    sel_at = select;
    if (!ok) begin
      timeout_fail("press_align");
    end else begin
      btn_play = m[0]; btn_stop = m[1]; btn_prev = m[2]; btn_next = m[3];
      @(negedge clk);
      btn_play = 1'b0; btn_stop = 1'b0; btn_prev = 1'b0; btn_next = 1'b0;
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [1:0] sel_at;
    int exp_len[4];
    bit got;
    exp_len[0] = 8; exp_len[1] = 4; exp_len[2] = 4; exp_len[3] = 12;

    repeat (2) @(negedge clk);
    chk("reset_state", 32'(state), 32'(S_STOP));
    chk("reset_select", 32'(select), 0);
    chk("reset_addr", 32'(note_addr), 0);
    chk("reset_tone", 32'(tone_en), 0);
    rst = 1'b0;

    // Play one full song from reset.
    run_q.delete();
    press(B_PLAY, 1'b0, -1, sel_at);
    chk("play_to_load", 32'(state), 32'(S_LOAD));
    @(negedge clk);
    chk("load_to_play", 32'(state), 32'(S_PLAY));
    chk("tone_in_play", 32'(tone_en), 1);
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (run_q.size() >= 4) begin got = 1'b1; break; end
    end
    if (!got) timeout_fail("song_runs");
    else begin
      for (int k = 0; k < 4; k++) begin
        chk("run_addr", 32'(run_q[k].addr), 32'(k));
        chk("run_len", 32'(run_q[k].len), 32'(exp_len[k]));
      end
    end
    repeat (3) @(negedge clk);
`ifdef MP3_AUTO_NEXT_EN
    chk("autonext_select", 32'(select), 1);
    chk("autonext_addr", 32'(note_addr), 0);
    chk("autonext_state", 32'(state), 32'(S_PLAY));
`else
    chk("end_state", 32'(state), 32'(S_STOP));
    chk("end_select", 32'(select), 0);
    chk("end_addr", 32'(note_addr), 0);
`endif

    // Held prev from select 0 in STOP: one step per sample period.
    press(B_STOP, 1'b0, -1, sel_at);
    pulse_rst();
    wait_smp(1'b0, -1, got);
    btn_prev = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("prev_hold_select", 32'(select), 32'(3 - k));
      chk("prev_hold_state", 32'(state), 32'(S_STOP));
      if (k < 2) repeat (7) @(negedge clk);
    end
    btn_prev = 1'b0;

    // Pause mid-note, hold, resume.
    press(B_PLAY, 1'b0, -1, sel_at);
    press(B_PLAY, 1'b1, -1, sel_at);
    chk("pause_state", 32'(state), 32'(S_PAUSE));
    chk("pause_tone", 32'(tone_en), 0);
    sel_at = 2'(note_addr);
    repeat (20) @(negedge clk);
    chk("pause_hold_state", 32'(state), 32'(S_PAUSE));
    chk("pause_hold_addr", 32'(note_addr[1:0]), 32'(sel_at));
    press(B_PLAY, 1'b0, -1, sel_at);
    chk("resume_state", 32'(state), 32'(S_PLAY));
    repeat (10) @(negedge clk);

    // Stop and next together during PLAY: stop wins.
    press(B_STOP, 1'b0, -1, sel_at);
    press(B_PLAY, 1'b0, -1, sel_at);
    press(B_STOP | B_NEXT, 1'b1, -1, sel_at);
    chk("stopnext_state", 32'(state), 32'(S_STOP));
    chk("stopnext_addr", 32'(note_addr), 0);
    chk("stopnext_select", 32'(select), 32'(sel_at));

    // Reset while paused at address 2 of song 1.
    pulse_rst();
    press(B_NEXT, 1'b0, -1, sel_at);
    press(B_PLAY, 1'b0, -1, sel_at);
    press(B_PLAY, 1'b1, 2, sel_at);
    chk("pre_rst_state", 32'(state), 32'(S_PAUSE));
    chk("pre_rst_addr", 32'(note_addr), 2);
    chk("pre_rst_select", 32'(select), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_pause_state", 32'(state), 32'(S_STOP));
    chk("rst_pause_select", 32'(select), 0);
    chk("rst_pause_addr", 32'(note_addr), 0);
    chk("rst_pause_tone", 32'(tone_en), 0);
    rst = 1'b0;

    // Random button traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 599) == 0);
      btn_stop = ($urandom_range(0, 39) == 0);
      btn_play = ($urandom_range(0, 4) == 0);
      btn_prev = ($urandom_range(0, 9) == 0);
      btn_next = ($urandom_range(0, 9) == 0);
    end
    rst = 1'b0; btn_stop = 1'b0; btn_play = 1'b0; btn_prev = 1'b0; btn_next = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
